hgcal_input_packer: RTL and testbench
=====================================

# hgcal_input_packer

Input stage of the HGCAL autoencoder LUT network. Accepts a stream of unsigned sensor-cell charge samples, quantizes each sample to Q_W bits with fixed thresholds, and packs N_IN quantized samples into one frame vector. The vector is presented to the first neuron-LUT layer (layer0) with a valid/ready handshake. Malformed frames are dropped and counted; no partial frame ever reaches layer0.

## Interface
- N_IN, 48: samples per frame (input features of layer0).
- IN_W, 8: sample width, unsigned.
- Q_W, 2: quantized width per sample.
- T1, 32: threshold for code 1.
- T2, 96: threshold for code 2.
- T3, 160: threshold for code 3.
- Parameter rule: T1 < T2 < T3 < 2^IN_W.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- s_data  in  IN_W  sample.
- s_last  in  1  marks the final sample of a frame.
- m_valid  out  1  frame vector valid.
- m_ready  in  1  layer0 side accepts the vector.
- m_data  out  N_IN*Q_W  packed vector; sample k occupies bits [k*Q_W +: Q_W].
- err  out  1  one-cycle pulse per dropped frame.
- drop_cnt  out  16  dropped-frame count; saturates at 16'hFFFF.

## Operation
- Quantization: q = 3 if x>=T3; 2 if x>=T2; 1 if x>=T1; else 0. Combinational, in the accept cycle.
- Packing: q of the accepted beat is written to acc[cnt]. cnt runs 0..N_IN-1, width clog2(N_IN).
- FSM states: FILL, PEND, DISCARD.
- FILL, s_ready=1, each beat is handled as follows:
  - cnt<N_IN-1, s_last=0: store q, cnt++.
  - cnt<N_IN-1, s_last=1: short frame. Drop the frame, cnt=0, err pulse, drop_cnt++, stay in FILL.
  - cnt==N_IN-1, s_last=0: long frame. Drop the frame, err pulse, drop_cnt++, go to DISCARD.
  - cnt==N_IN-1, s_last=1: frame complete, cnt=0. If the output is free (m_valid==0, or m_valid&&m_ready in this same cycle), load m_data with the completed vector and set m_valid next cycle; stay in FILL. Otherwise hold the vector in acc and go to PEND.
- PEND, s_ready=0: on m_valid&&m_ready, load m_data from acc, keep m_valid=1, go to FILL.
- DISCARD, s_ready=1: swallow beats with no other effect. On a beat with s_last=1, go to FILL with cnt=0.
- Output hold: m_valid and m_data stay stable until m_valid&&m_ready. m_valid clears after a handshake only if no new vector is loaded in that cycle.
- Reset: state=FILL, cnt=0, acc=0, m_valid=0, m_data=0, err=0, drop_cnt=0. s_ready=0 while rst=1. Any frame in flight is lost and is not counted as dropped.

## Timing
- Latency: when the last beat is accepted in cycle t with the output free, m_valid=1 in cycle t+1.
- Throughput: one sample per cycle. A frame may complete in the same cycle the previous vector is drained, with no bubble.
- s_ready is registered-state-derived only; it does not depend combinationally on s_valid.
- m_ready reaches the registers only; there is no combinational path from m_ready to s_ready. PEND absorbs one full frame of backpressure.
- err is asserted in the cycle after the offending beat, for exactly one cycle.
- drop_cnt updates in the same cycle as err.

## Structure
- Shared package hgcal_in_pkg holds:
  - default Q_W, IN_W and thresholds;
  - the state enum {FILL, PEND, DISCARD};
  - the drop counter width constant.
- Sub-module hgcal_quantizer: combinational IN_W -> Q_W threshold compare, parameterized by T1..T3. It is reused for any later re-quantization stage.

## Test plan
All scenarios use N_IN=4, IN_W=8, thresholds 32/96/160.
- Basic frame: samples 10, 40, 100, 200 (last on 200), m_ready=1 -> one cycle later m_data=8'b11100100, m_valid=1; err stays 0.
- Backpressure: m_ready=0, two back-to-back frames (0,0,0,255) then (255,0,0,0). First m_data=8'hC0; s_ready drops after the 8th beat (PEND). On m_ready=1, m_data becomes 8'h03 the next cycle and s_ready returns to 1.
- Short frame: s_last on the 2nd sample -> err pulse, drop_cnt=1, no m_valid. The following valid frame (all samples 96) -> m_data=8'hAA.
- Long frame: 6 samples with s_last on the 6th -> err once at the 4th beat, drop_cnt=1, beats 5-6 swallowed, no m_valid. The next good frame passes through.
- Reset mid-frame: rst after 2 beats -> all outputs 0 and s_ready=0 during rst. The next 4-beat frame of 31, 32, 95, 160 -> m_data=8'b11010100; drop_cnt=0.
- Saturation: force 65536 short frames -> drop_cnt holds 16'hFFFF, err still pulses for each dropped frame.

Source files
------------

// File: rtl/hgcal_in_pkg.sv
// Shared definitions for the HGCAL autoencoder input stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the default sample/code widths and quantization thresholds, the
// packer FSM state type and the dropped-frame counter width.
package hgcal_in_pkg;

    // Default sample format and quantization thresholds.
    localparam int DEF_IN_W = 8;
    localparam int DEF_Q_W  = 2;
    localparam int DEF_T1   = 32;
    localparam int DEF_T2   = 96;
    localparam int DEF_T3   = 160;

    // Dropped-frame counter width; the counter saturates at all-ones.
    localparam int DROP_W = 16;

    // Packer FSM states.
    typedef enum logic [1:0] {
        FILL    = 2'd0,  // accepting beats of a frame
        PEND    = 2'd1,  // completed vector parked in acc, waiting for output
        DISCARD = 2'd2   // swallowing the tail of an over-long frame
    } state_t;

endpackage

// File: rtl/hgcal_quantizer.sv
// Threshold quantizer: maps an unsigned sample to a small code.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
//
// Ports:
//   x  in  IN_W  unsigned sample
//   q  out Q_W   code: 3 if x>=T3, 2 if x>=T2, 1 if x>=T1, else 0
//
// Thresholds must satisfy T1 < T2 < T3 < 2**IN_W. Also used by any later
// re-quantization stage, so it carries no state.
module hgcal_quantizer
    import hgcal_in_pkg::*;
#(
    parameter int IN_W = DEF_IN_W,
    parameter int Q_W  = DEF_Q_W,
    parameter int T1   = DEF_T1,
    parameter int T2   = DEF_T2,
    parameter int T3   = DEF_T3
) (
    input  logic [IN_W-1:0] x,
    output logic [Q_W-1:0]  q
);

    localparam logic [IN_W-1:0] TH1 = IN_W'(T1);
    localparam logic [IN_W-1:0] TH2 = IN_W'(T2);
    localparam logic [IN_W-1:0] TH3 = IN_W'(T3);

    always_comb begin
        q = '0;
        if (x >= TH3) begin
            q = Q_W'(3);
        end else if (x >= TH2) begin
            q = Q_W'(2);
        end else if (x >= TH1) begin
            q = Q_W'(1);
        end
    end

endmodule

// File: rtl/hgcal_input_packer.sv
// Quantizes a sample stream and packs N_IN codes into one frame vector for layer0.
// Latency: last beat accepted in cycle t with the output free -> m_valid in t+1.
// Backpressure: one completed frame parks in acc (PEND, s_ready=0); s_ready never sees m_ready.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   s_valid/s_ready   sample handshake; s_data sample, s_last end of frame
//   m_valid/m_ready   frame vector handshake; m_data sample k at [k*Q_W +: Q_W]
//   err               one-cycle pulse per dropped (short or long) frame
//   drop_cnt          saturating dropped-frame count
module hgcal_input_packer
    import hgcal_in_pkg::*;
#(
    parameter int N_IN = 48,
    parameter int IN_W = DEF_IN_W,
    parameter int Q_W  = DEF_Q_W,
    parameter int T1   = DEF_T1,
    parameter int T2   = DEF_T2,
    parameter int T3   = DEF_T3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_W-1:0]      s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N_IN*Q_W-1:0]  m_data,
    output logic                 err,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam int VEC_W = N_IN * Q_W;
    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_IN - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [VEC_W-1:0]   acc;
    logic [VEC_W-1:0]   frame_vec;
    logic [Q_W-1:0]     q;
    logic               beat;
    logic               at_last_slot;
    logic               out_free;

    hgcal_quantizer #(
        .IN_W (IN_W),
        .Q_W  (Q_W),
        .T1   (T1),
        .T2   (T2),
        .T3   (T3)
    ) u_quant (
        .x (s_data),
        .q (q)
    );

    // Depends only on registered state (and reset), never on s_valid or m_ready.
    assign s_ready      = ~rst & (state != PEND);
    assign beat         = s_valid & s_ready;
    assign at_last_slot = (cnt == LAST_SLOT);
    // Output register can take a new vector this cycle.
    assign out_free     = ~m_valid | m_ready;

    // acc with the current beat's code merged in; on the final beat this is
    // the completed vector, so it can go straight to m_data without a bubble.
    always_comb begin
        frame_vec = acc;
        frame_vec[cnt*Q_W +: Q_W] = q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            cnt      <= '0;
            acc      <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            err      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            err <= 1'b0;

            // Default drain; a load later in this block overrides the clear.
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            unique case (state)
                FILL: begin
                    if (beat) begin
                        if (!at_last_slot) begin
                            if (s_last) begin
                                // Short frame: drop and restart at slot 0.
                                cnt <= '0;
                                err <= 1'b1;
                                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
                            end else begin
                                acc <= frame_vec;
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            cnt <= '0;
                            if (s_last) begin
                                // Complete frame. Keep it in acc as well so
                                // PEND can present it later.
                                acc <= frame_vec;
                                if (out_free) begin
                                    m_data  <= frame_vec;
                                    m_valid <= 1'b1;
                                end else begin
                                    state <= PEND;
                                end
                            end else begin
                                // Long frame: drop now, swallow beats to s_last.
                                err   <= 1'b1;
                                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
                                state <= DISCARD;
                            end
                        end
                    end
                end

                PEND: begin
                    // m_valid is necessarily set here; the handshake frees
                    // the output and the parked vector takes its place.
                    if (m_ready) begin
                        m_data  <= acc;
                        m_valid <= 1'b1;
                        state   <= FILL;
                    end
                end

                DISCARD: begin
                    if (beat && s_last) begin
                        cnt   <= '0;
                        state <= FILL;
                    end
                end

                default: begin
                    state <= FILL;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Self-checking bench for hgcal_input_packer with N_IN=4, IN_W=8, thresholds 32/96/160.
// A frame-level reference model predicts vectors and drops from the accepted beats.
// A forked monitor checks every output handshake and the output-hold rule.
module tb_hgcal_input_packer;

    localparam int N    = 4;
    localparam int IW   = 8;
    localparam int QW   = 2;
    localparam int TH1  = 32;
    localparam int TH2  = 96;
    localparam int TH3  = 160;
    localparam int VW   = N * QW;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [IW-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [VW-1:0] m_data;
    logic          err;
    logic [15:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int            cur[$];
    bit            discarding;
    logic [VW-1:0] exp_q[$];
    int            drops;
    int            err_seen;
    bit            rand_ready;

    always #5 clk = ~clk;

    hgcal_input_packer #(
        .N_IN (N),
        .IN_W (IW),
        .Q_W  (QW),
        .T1   (TH1),
        .T2   (TH2),
        .T3   (TH3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .err      (err),
        .drop_cnt (drop_cnt)
    );

    function automatic logic [1:0] ref_q(int x);
        if (x >= TH3) return 2'd3;
        if (x >= TH2) return 2'd2;
        if (x >= TH1) return 2'd1;
        return 2'd0;
    endfunction

    function automatic int exp_drop_cnt();
        return (drops > 65535) ? 65535 : drops;
    endfunction

    // Frame rules: exactly N beats ending in s_last form a vector; ending
    // early is a drop; reaching N beats without s_last is a drop followed by
    // discarding everything up to and including the next s_last.
    function automatic void model_accept(int x, logic last);
        logic [VW-1:0] v;
        if (discarding) begin
            if (last) discarding = 1'b0;
            return;
        end
        cur.push_back(x);
        if (cur.size() == N) begin
            if (last) begin
                v = '0;
                for (int k = 0; k < N; k++) v[k*QW +: QW] = ref_q(cur[k]);
                exp_q.push_back(v);
            end else begin
                drops++;
                discarding = 1'b1;
            end
            cur.delete();
        end else if (last) begin
            drops++;
            cur.delete();
        end
    endfunction

    function automatic void model_reset();
        cur.delete();
        exp_q.delete();
        discarding = 1'b0;
        drops      = 0;
        err_seen   = 0;
    endfunction

    task automatic monitor();
        bit            hold_v;
        logic [VW-1:0] hold_d;
        logic [VW-1:0] e;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    checks++;
                    if (m_valid !== 1'b1 || m_data !== hold_d) begin
                        errors++;
                        $display("FAIL output_hold: m_valid=%b m_data=%h, required 1 %h", m_valid, m_data, hold_d);
                    end
                end
                if (m_valid === 1'b1 && m_ready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_vector: m_data=%h, no vector expected", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_data !== e) begin
                            errors++;
                            $display("FAIL vector: m_data=%h, required %h", m_data, e);
                        end
                    end
                end
                if (err === 1'b1) err_seen++;
                hold_v = (m_valid === 1'b1) && (m_ready !== 1'b1);
                hold_d = m_data;
            end
        end
    endtask

    task automatic idle(int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) begin
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input int d, input logic last);
        bit ok;
        int waited;
        s_valid = 1'b1;
        s_data  = IW'(d);
        s_last  = last;
        waited  = 0;
        forever begin
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = (s_ready === 1'b1);
            @(posedge clk);
            #1;
            if (ok) begin
                model_accept(d, last);
                break;
            end
            waited++;
            if (waited > 1000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: s_ready=%b, required 1 within 1000 cycles", s_ready);
                break;
            end
        end
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || err !== 1'b0 || drop_cnt !== 16'h0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: m_valid=%b m_data=%h err=%b drop_cnt=%h s_ready=%b, required all 0",
                     m_valid, m_data, err, drop_cnt, s_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: s_ready=%b, required 1", s_ready);
        end
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        send_beat(10, 1'b0);
        send_beat(40, 1'b0);
        send_beat(100, 1'b0);
        send_beat(200, 1'b1);
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'b11100100) begin
            errors++;
            $display("FAIL basic_latency: m_valid=%b m_data=%b, required 1 11100100", m_valid, m_data);
        end
        idle(2);
        checks++;
        if (m_valid !== 1'b0 || err_seen != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drain: m_valid=%b err_seen=%0d pending=%0d, required 0 0 0",
                     m_valid, err_seen, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        send_beat(0, 1'b0);
        send_beat(0, 1'b0);
        send_beat(0, 1'b0);
        send_beat(255, 1'b1);
        send_beat(255, 1'b0);
        send_beat(0, 1'b0);
        send_beat(0, 1'b0);
        send_beat(0, 1'b1);
        s_valid = 1'b0;
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'hC0) begin
            errors++;
            $display("FAIL bp_pend: s_ready=%b m_valid=%b m_data=%h, required 0 1 c0", s_ready, m_valid, m_data);
        end
        idle(3);
        checks++;
        if (s_ready !== 1'b0 || m_data !== 8'hC0) begin
            errors++;
            $display("FAIL bp_stall: s_ready=%b m_data=%h, required 0 c0", s_ready, m_data);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h03 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: m_valid=%b m_data=%h s_ready=%b, required 1 03 1", m_valid, m_data, s_ready);
        end
        idle(1);
        checks++;
        if (m_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: m_valid=%b pending=%0d, required 0 0", m_valid, exp_q.size());
        end
    endtask

    task automatic test_short();
        m_ready = 1'b1;
        send_beat(50, 1'b0);
        send_beat(60, 1'b1);
        s_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || drop_cnt !== 16'd1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_drop: err=%b drop_cnt=%0d m_valid=%b, required 1 1 0", err, drop_cnt, m_valid);
        end
        idle(1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL short_err_width: err=%b, required 0", err);
        end
        for (int i = 0; i < N; i++) send_beat(96, 1'(i == N - 1));
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hAA) begin
            errors++;
            $display("FAIL short_next: m_valid=%b m_data=%h, required 1 aa", m_valid, m_data);
        end
        idle(2);
    endtask

    task automatic test_long();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_beat(200, 1'(i == 5));
            if (i == 3) begin
                checks++;
                if (err !== 1'b1 || drop_cnt !== 16'd2) begin
                    errors++;
                    $display("FAIL long_drop: err=%b drop_cnt=%0d, required 1 2", err, drop_cnt);
                end
            end
            if (i == 4 || i == 5) begin
                checks++;
                if (err !== 1'b0 || m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL long_swallow beat %0d: err=%b m_valid=%b, required 0 0", i + 1, err, m_valid);
                end
            end
        end
        send_beat(160, 1'b0);
        send_beat(0, 1'b0);
        send_beat(95, 1'b0);
        send_beat(32, 1'b1);
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'b01010011 || drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL long_next: m_valid=%b m_data=%b drop_cnt=%0d, required 1 01010011 2",
                     m_valid, m_data, drop_cnt);
        end
        idle(2);
        checks++;
        if (err_seen != drops || exp_q.size() != 0) begin
            errors++;
            $display("FAIL long_totals: err_seen=%0d pending=%0d, required %0d 0", err_seen, exp_q.size(), drops);
        end
    endtask

    task automatic test_reset_midframe();
        m_ready = 1'b1;
        send_beat(200, 1'b0);
        send_beat(200, 1'b0);
        s_valid = 1'b1;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || err !== 1'b0 || drop_cnt !== 16'h0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: m_valid=%b m_data=%h err=%b drop_cnt=%h s_ready=%b, required all 0",
                     m_valid, m_data, err, drop_cnt, s_ready);
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        send_beat(31, 1'b0);
        send_beat(32, 1'b0);
        send_beat(95, 1'b0);
        send_beat(160, 1'b1);
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'b11010100 || drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL midframe_next: m_valid=%b m_data=%b drop_cnt=%0d, required 1 11010100 0",
                     m_valid, m_data, drop_cnt);
        end
        idle(2);
    endtask

    task automatic test_random();
        int len;
        int d;
        int pick;
        rand_ready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            len = ($urandom_range(0, 9) < 6) ? N : int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                pick = int'($urandom_range(0, 3));
                if (pick == 0) begin
                    case ($urandom_range(0, 5))
                        0: d = TH1 - 1;
                        1: d = TH1;
                        2: d = TH2 - 1;
                        3: d = TH2;
                        4: d = TH3 - 1;
                        default: d = TH3;
                    endcase
                end else begin
                    d = int'($urandom_range(0, 255));
                end
                send_beat(d, 1'(i == len - 1));
            end
            idle(int'($urandom_range(0, 2)));
        end
        rand_ready = 1'b0;
        m_ready = 1'b1;
        idle(6);
        checks++;
        if (exp_q.size() != 0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: pending=%0d m_valid=%b, required 0 0", exp_q.size(), m_valid);
        end
        checks++;
        if (err_seen != drops || drop_cnt !== 16'(exp_drop_cnt())) begin
            errors++;
            $display("FAIL random_drops: err_seen=%0d drop_cnt=%0d, required %0d %0d",
                     err_seen, drop_cnt, drops, exp_drop_cnt());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            send_beat(0, 1'b1);
            if (i == 65533 || i == 65534 || i == 65536) begin
                checks++;
                if (drop_cnt !== 16'(exp_drop_cnt()) || err !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_count at frame %0d: drop_cnt=%h err=%b, required %h 1",
                             i + 1, drop_cnt, err, 16'(exp_drop_cnt()));
                end
            end
        end
        idle(2);
        checks++;
        if (drop_cnt !== 16'hFFFF || err_seen != 65537) begin
            errors++;
            $display("FAIL sat_final: drop_cnt=%h err_pulses=%0d, required ffff 65537", drop_cnt, err_seen);
        end
    endtask

    initial begin
        rst        = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        m_ready    = 1'b0;
        rand_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_short();
        test_long();
        test_reset_midframe();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
